// File: rtl/wr_pntrs_and_full.sv
// Write-side pointer and flag stage of a dual-clock FIFO: binary/Gray write pointer, rd-pointer synchronizer, full/usedw.
// Optional almost-full flag is built only when WR_ALMOST_FULL_EN is defined.
module wr_pntrs_and_full #(
    parameter int AWIDTH          = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int ALMOST_FULL_LVL = 6
) (
    input  logic              wr_clk_i,
    input  logic              sclr_i,
    input  logic              wr_req_i,
    input  logic [AWIDTH:0]   rd_pntr_gray_i,
    output logic              wr_en_o,
    output logic [AWIDTH-1:0] wr_pntr_o,
    output logic [AWIDTH:0]   wr_pntr_gray_wr_o,
    output logic              wr_full_o,
    output logic [AWIDTH:0]   wr_usedw_o,
    output logic              wr_almost_full_o
);

    localparam int PW = AWIDTH + 1;

    if (AWIDTH < 2) begin : g_chk_awidth
        $error("wr_pntrs_and_full: AWIDTH must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("wr_pntrs_and_full: SYNC_STAGES must be >= 2");
    end
    if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > (2 ** AWIDTH)) begin : g_chk_af
        $error("wr_pntrs_and_full: ALMOST_FULL_LVL out of range");
    end

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int k = PW - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    logic [PW-1:0] wr_pntr_bin;
    logic [PW-1:0] wr_pntr_bin_next;
    logic [PW-1:0] wr_gray_next;
    logic [PW-1:0] rd_sync [SYNC_STAGES];
    logic [PW-1:0] rd_gray_s;
    logic [PW-1:0] rd_pntr_bin_s;
    logic [PW-1:0] usedw_next;
    logic          full_next;
    logic          wr_accept;

    assign wr_accept        = wr_req_i & ~wr_full_o;
    assign wr_en_o          = wr_accept & ~sclr_i;
    assign wr_pntr_bin_next = wr_pntr_bin + PW'(wr_accept);
    assign wr_gray_next     = bin2gray(wr_pntr_bin_next);
    assign wr_pntr_o        = wr_pntr_bin[AWIDTH-1:0];

    assign rd_gray_s     = rd_sync[SYNC_STAGES-1];
    assign rd_pntr_bin_s = gray2bin(rd_gray_s);

    // Full when the next write pointer is exactly one lap ahead of the synchronized read pointer.
    assign full_next  = (wr_gray_next == {~rd_gray_s[AWIDTH:AWIDTH-1], rd_gray_s[AWIDTH-2:0]});
    assign usedw_next = wr_pntr_bin_next - rd_pntr_bin_s;

    always_ff @(posedge wr_clk_i) begin
        if (sclr_i) begin
            wr_pntr_bin       <= '0;
            wr_pntr_gray_wr_o <= '0;
            wr_full_o         <= 1'b0;
            wr_usedw_o        <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= '0;
            end
        end else begin
            wr_pntr_bin       <= wr_pntr_bin_next;
            wr_pntr_gray_wr_o <= wr_gray_next;
            wr_full_o         <= full_next;
            wr_usedw_o        <= usedw_next;
            rd_sync[0]        <= rd_pntr_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= rd_sync[i-1];
            end
        end
    end

`ifdef WR_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LVL);

    always_ff @(posedge wr_clk_i) begin
        if (sclr_i) begin
            wr_almost_full_o <= 1'b0;
        end else begin
            wr_almost_full_o <= (usedw_next >= AF_LVL);
        end
    end
`else
    assign wr_almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_wr_pntrs_and_full.sv
// Directed bench for wr_pntrs_and_full at AWIDTH=3, SYNC_STAGES=2, ALMOST_FULL_LVL=6.
module tb_wr_pntrs_and_full;

    localparam int AW = 3;
`ifdef WR_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic          wr_clk_i = 1'b0;
    logic          sclr_i;
    logic          wr_req_i;
    logic [AW:0]   rd_pntr_gray_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_pntr_o;
    logic [AW:0]   wr_pntr_gray_wr_o;
    logic          wr_full_o;
    logic [AW:0]   wr_usedw_o;
    logic          wr_almost_full_o;

    int n_cmp = 0;
    int n_err = 0;

    wr_pntrs_and_full #(.AWIDTH(AW), .SYNC_STAGES(2), .ALMOST_FULL_LVL(6)) dut (
        .wr_clk_i          (wr_clk_i),
        .sclr_i            (sclr_i),
        .wr_req_i          (wr_req_i),
        .rd_pntr_gray_i    (rd_pntr_gray_i),
        .wr_en_o           (wr_en_o),
        .wr_pntr_o         (wr_pntr_o),
        .wr_pntr_gray_wr_o (wr_pntr_gray_wr_o),
        .wr_full_o         (wr_full_o),
        .wr_usedw_o        (wr_usedw_o),
        .wr_almost_full_o  (wr_almost_full_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk_i);
        #1;
    endtask

    function automatic logic [AW:0] g(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference model state for the interleaved phase
    logic [AW:0] m_wr, m_rd, m_s0, m_s1, m_used;
    logic        m_full, m_req, m_acc;
    int          n_acc;
    bit          wrapped;

    initial begin
        // Reset with a pending request
        sclr_i = 1'b1; wr_req_i = 1'b1; rd_pntr_gray_i = '0;
        #1;
        chk("en_in_reset", wr_en_o, 0);
        tick();
        chk("rst_ptr", wr_pntr_o, 0);
        chk("rst_gray", wr_pntr_gray_wr_o, 4'b0000);
        chk("rst_full", wr_full_o, 0);
        chk("rst_usedw", wr_usedw_o, 0);
        chk("rst_af", wr_almost_full_o, 0);

        // Eight back-to-back writes to full
        sclr_i = 1'b0; wr_req_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("fill_en", wr_en_o, 1);
            tick();
            chk("fill_usedw", wr_usedw_o, k);
            chk("fill_af", wr_almost_full_o, (AF_EN && k >= 6) ? 1 : 0);
            chk("fill_full", wr_full_o, (k == 8) ? 1 : 0);
        end
        chk("full_ptr", wr_pntr_o, 0);
        chk("full_gray", wr_pntr_gray_wr_o, 4'b1100);
        chk("ninth_en", wr_en_o, 0);
        tick();
        chk("ninth_ptr", wr_pntr_o, 0);
        chk("ninth_gray", wr_pntr_gray_wr_o, 4'b1100);
        chk("ninth_usedw", wr_usedw_o, 8);
        chk("ninth_full", wr_full_o, 1);

        // One read seen through the synchronizer
        wr_req_i = 1'b0; rd_pntr_gray_i = 4'b0001;
        tick(); chk("rd_e1_full", wr_full_o, 1);
        tick(); chk("rd_e2_full", wr_full_o, 1);
        tick(); chk("rd_e3_full", wr_full_o, 0);
        chk("rd_e3_usedw", wr_usedw_o, 7);
        wr_req_i = 1'b1;
        #1;
        chk("refill_en", wr_en_o, 1);
        tick();
        chk("refill_full", wr_full_o, 1);
        chk("refill_usedw", wr_usedw_o, 8);
        chk("refill_gray", wr_pntr_gray_wr_o, 4'b1101);

        // Interleaved writes/reads across the pointer wrap
        m_wr = 4'd9; m_rd = 4'd1; m_s0 = 4'd1; m_s1 = 4'd1; m_full = 1'b1;
        n_acc = 0; wrapped = 1'b0;
        for (int i = 0; i < 60 && n_acc < 20; i++) begin
            m_req = (i % 4) != 3;
            if ((i % 3) != 1 && m_rd != m_wr) m_rd = m_rd + 1'b1;
            wr_req_i = m_req;
            rd_pntr_gray_i = g(m_rd);
            #1;
            m_acc = m_req & ~m_full;
            chk("wrap_en", wr_en_o, m_acc);
            if (m_acc && m_wr == 4'd15) chk("wrap_gray_pre", wr_pntr_gray_wr_o, 4'b1000);
            tick();
            if (m_acc) begin
                if (m_wr == 4'd15) wrapped = 1'b1;
                m_wr = m_wr + 1'b1;
                n_acc++;
            end
            m_used = m_wr - m_s1;
            m_full = (m_used == 4'd8);
            m_s1 = m_s0;
            m_s0 = m_rd;
            chk("wrap_usedw", wr_usedw_o, m_used);
            chk("wrap_full", wr_full_o, m_full);
            chk("wrap_gray", wr_pntr_gray_wr_o, g(m_wr));
            chk("wrap_ptr", wr_pntr_o, m_wr[AW-1:0]);
            if (m_acc && m_wr == 4'd0) chk("wrap_gray_post", wr_pntr_gray_wr_o, 4'b0000);
        end
        chk("wrap_seen", wrapped, 1);
        chk("wrap_count", n_acc, 20);

        // Drain, fill to five, then reset mid-stream
        wr_req_i = 1'b0; rd_pntr_gray_i = g(m_wr);
        tick(); tick(); tick();
        chk("drain_usedw", wr_usedw_o, 0);
        wr_req_i = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_usedw", wr_usedw_o, 5);
        chk("pre_rst_af", wr_almost_full_o, 0);
        sclr_i = 1'b1;
        #1;
        chk("mid_rst_en", wr_en_o, 0);
        tick();
        sclr_i = 1'b0; rd_pntr_gray_i = '0;
        chk("post_rst_ptr", wr_pntr_o, 0);
        chk("post_rst_gray", wr_pntr_gray_wr_o, 0);
        chk("post_rst_usedw", wr_usedw_o, 0);
        chk("post_rst_full", wr_full_o, 0);
        #1;
        chk("first_wr_en", wr_en_o, 1);
        chk("first_wr_addr", wr_pntr_o, 0);
        tick();
        chk("first_wr_usedw", wr_usedw_o, 1);
        chk("first_wr_ptr", wr_pntr_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
